// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single CPU-side port of the memory crossbar between two
// requesters: port 0 (CPU load/store unit) and port 1 (DMA/debug loader).
// One word access is granted per cycle under a hold-limited round-robin
// policy, and the 1-cycle-latency read data is routed back to the requester
// that issued the read.
//
// Handshake: i_pN_req is a "valid" that the requester holds, together with its
// payload, until it sees o_pN_gnt in the same cycle. o_pN_gnt acts as the
// "ready" for that cycle. The access is transferred on a cycle where both are
// high. Nothing is buffered here. o_pN_rvalid is a single-cycle strobe with no
// back-pressure.
//
// Parameters
//   MAX_HOLD      max consecutive grants to one port while the other requests
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   i_pN_req/addr/data/wren/mask     requester N access (N = 0, 1)
//   o_pN_gnt                         requester N access accepted this cycle
//   o_pN_rvalid / o_pN_rdata         read result strobe / data for requester N
//   o_addr/o_data/o_wren/o_mask      access driven to the crossbar
//   i_rdata                          crossbar read data, one cycle after a read
//   o_dbg_last/run/rd_pend/rd_port   internal arbitration and read-tracking state
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MAX_HOLD = 4,
  localparam int RUN_W = $clog2(MAX_HOLD + 1)
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             i_p0_req,
  input  logic [29:0]      i_p0_addr,
  input  logic [31:0]      i_p0_data,
  input  logic             i_p0_wren,
  input  logic [3:0]       i_p0_mask,
  output logic             o_p0_gnt,
  output logic             o_p0_rvalid,
  output logic [31:0]      o_p0_rdata,

  input  logic             i_p1_req,
  input  logic [29:0]      i_p1_addr,
  input  logic [31:0]      i_p1_data,
  input  logic             i_p1_wren,
  input  logic [3:0]       i_p1_mask,
  output logic             o_p1_gnt,
  output logic             o_p1_rvalid,
  output logic [31:0]      o_p1_rdata,

  output logic [29:0]      o_addr,
  output logic [31:0]      o_data,
  output logic             o_wren,
  output logic [3:0]       o_mask,
  input  logic [31:0]      i_rdata,

  output logic             o_dbg_last,
  output logic [RUN_W-1:0] o_dbg_run,
  output logic             o_dbg_rd_pend,
  output logic             o_dbg_rd_port
);

  localparam logic [RUN_W-1:0] MAX_RUN = RUN_W'(MAX_HOLD);
  localparam logic [RUN_W-1:0] ONE_RUN = RUN_W'(1);

  // Arbitration state: port of most recent grant and its consecutive-grant
  // count (saturating at MAX_RUN).
  logic             last_q, last_d;
  logic [RUN_W-1:0] run_q, run_d;

  // Read tracking: a read issued this cycle returns data next cycle.
  logic             rd_pend_q, rd_pend_d;
  logic             rd_port_q, rd_port_d;

  logic gnt0, gnt1, any_gnt;

  // ---------------------------------------------------------------------------
  // Grant decision (combinational, same cycle as the request).
  // Under contention the current owner keeps the port until it has used
  // MAX_HOLD consecutive grants, then the other port gets it.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (i_p0_req && i_p1_req) begin
        if (run_q < MAX_RUN) begin
          gnt1 = last_q;
        end else begin
          gnt1 = ~last_q;
        end
        gnt0 = ~gnt1;
      end else begin
        gnt0 = i_p0_req;
        gnt1 = i_p1_req;
      end
    end
  end

  assign any_gnt  = gnt0 | gnt1;
  assign o_p0_gnt = gnt0;
  assign o_p1_gnt = gnt1;

  // ---------------------------------------------------------------------------
  // Payload mux. Idle cycles drive all zeros so memory is never written by
  // stale payload.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_addr = '0;
    o_data = '0;
    o_wren = 1'b0;
    o_mask = '0;
    if (gnt0) begin
      o_addr = i_p0_addr;
      o_data = i_p0_data;
      o_wren = i_p0_wren;
      o_mask = i_p0_mask;
    end else if (gnt1) begin
      o_addr = i_p1_addr;
      o_data = i_p1_data;
      o_wren = i_p1_wren;
      o_mask = i_p1_mask;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Idle cycles keep last/run so the previous owner's run
  // resumes at the next contention. rd_pend is only set by a granted read.
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d    = last_q;
    run_d     = run_q;
    rd_pend_d = 1'b0;
    rd_port_d = rd_port_q;
    if (any_gnt) begin
      if (gnt1 == last_q) begin
        run_d = (run_q == MAX_RUN) ? run_q : run_q + ONE_RUN;
      end else begin
        last_d = gnt1;
        run_d  = ONE_RUN;
      end
      rd_pend_d = ~o_wren;
      rd_port_d = gnt1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q    <= 1'b0;
      run_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      run_q     <= run_d;
      rd_pend_q <= rd_pend_d;
      rd_port_q <= rd_port_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return. Data is broadcast, only the valid strobe is steered. The
  // strobe is masked while rst is high so a read issued just before reset
  // never reports a result.
  // ---------------------------------------------------------------------------
  assign o_p0_rvalid = rd_pend_q & ~rd_port_q & ~rst;
  assign o_p1_rvalid = rd_pend_q &  rd_port_q & ~rst;
  assign o_p0_rdata  = i_rdata;
  assign o_p1_rdata  = i_rdata;

  assign o_dbg_last    = last_q;
  assign o_dbg_run     = run_q;
  assign o_dbg_rd_pend = rd_pend_q;
  assign o_dbg_rd_port = rd_port_q;

endmodule
